// File: rtl/brick_field_sequencer.sv
// brick_field_sequencer: owns the brick-alive bitmap and turns field events
// (full redraw, ball hit) into draw jobs for the rectangle drawer, driving
// its go-high-then-low handshake and waiting for draw_done between jobs.
// Optional build macro: BRICK_TOUGH_EN (row-0 bricks survive one hit).
module brick_field_sequencer #(
    parameter int ROWS     = 4,
    parameter int COLS     = 8,
    parameter int BRICK_W  = 40,
    parameter int BRICK_H  = 16,
    parameter int GAP      = 2,
    parameter int ORIGIN_X = 0,
    parameter int ORIGIN_Y = 32
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic       hit_valid,
    input  logic [2:0] hit_row,
    input  logic [3:0] hit_col,
    output logic       hit_ready,
    input  logic       draw_done,
    output logic       go,
    output logic [9:0] x_out,
    output logic [9:0] y_out,
    output logic [9:0] width,
    output logic [9:0] height,
    output logic [2:0] colour,
    output logic       busy,
    output logic [7:0] bricks_left,
    output logic       field_clear
);
    localparam int         NB      = ROWS * COLS;
    localparam logic [9:0] PITCH_X = 10'(BRICK_W + GAP);
    localparam logic [9:0] PITCH_Y = 10'(BRICK_H + GAP);
    localparam logic [9:0] ORG_X   = 10'(ORIGIN_X);
    localparam logic [9:0] ORG_Y   = 10'(ORIGIN_Y);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SCAN  = 3'd1,
        S_HIT   = 3'd2,
        S_GO_HI = 3'd3,
        S_GO_LO = 3'd4,
        S_WAIT  = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [NB-1:0]   alive_q;
    logic [7:0]      left_q;
    logic [2:0]      row_q;
    logic [3:0]      col_q;
    logic            job_hit_q;
    logic            go_cnt_q;
    logic [9:0]      x_q, y_q;
    logic [2:0]      colour_q;
`ifdef BRICK_TOUGH_EN
    logic [COLS-1:0] cracked_q;
    logic [COLS-1:0] col_sel_s;
    logic            cracked_s;
`endif

    logic [7:0]      idx_s;
    logic [NB-1:0]   sel_s;
    logic            in_range_s;
    logic            alive_s;
    logic            last_s;
    logic [2:0]      nxt_row_s;
    logic [3:0]      nxt_col_s;
    logic [9:0]      x_s, y_s;
    logic [2:0]      scan_colour_s;

    // Row palette, repeating every four rows.
    function automatic logic [2:0] row_colour(input logic [2:0] r);
        case (r[1:0])
            2'd0:    row_colour = 3'b100;
            2'd1:    row_colour = 3'b110;
            2'd2:    row_colour = 3'b010;
            2'd3:    row_colour = 3'b011;
            default: row_colour = 3'b000;
        endcase
    endfunction

    assign idx_s      = 8'(row_q) * 8'(COLS) + 8'(col_q);
    assign sel_s      = NB'(1) << idx_s;
    // Hits may name a cell outside the grid; such a cell is never alive.
    assign in_range_s = ({1'b0, row_q} < 4'(ROWS)) && ({1'b0, col_q} < 5'(COLS));
    assign alive_s    = in_range_s && ((alive_q & sel_s) != '0);
    assign last_s     = (row_q == 3'(ROWS - 1)) && (col_q == 4'(COLS - 1));
    assign x_s        = ORG_X + 10'(col_q) * PITCH_X;
    assign y_s        = ORG_Y + 10'(row_q) * PITCH_Y;

`ifdef BRICK_TOUGH_EN
    assign col_sel_s  = COLS'(1) << col_q;
    assign cracked_s  = (row_q == 3'd0) && ((cracked_q & col_sel_s) != '0);
`endif

    // Scan colour and row-major index advance for the current cell.
    always_comb begin
        scan_colour_s = row_colour(row_q);
`ifdef BRICK_TOUGH_EN
        if (row_q == 3'd0) begin
            scan_colour_s = cracked_s ? 3'b100 : 3'b101;
        end else begin
            scan_colour_s = row_colour(row_q);
        end
`endif
        if (col_q == 4'(COLS - 1)) begin
            nxt_col_s = 4'd0;
            nxt_row_s = row_q + 3'd1;
        end else begin
            nxt_col_s = col_q + 4'd1;
            nxt_row_s = row_q;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start wins over a simultaneous hit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SCAN;
                end else if (hit_valid) begin
                    state_d = S_HIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SCAN: begin
                if (alive_s) begin
                    state_d = S_GO_HI;
                end else if (last_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_SCAN;
                end
            end
            S_HIT:   state_d = alive_s ? S_GO_HI : S_IDLE;
            S_GO_HI: state_d = go_cnt_q ? S_GO_LO : S_GO_HI;
            S_GO_LO: state_d = S_WAIT;
            S_WAIT: begin
                if (!draw_done) begin
                    state_d = S_WAIT;
                end else if (job_hit_q || last_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_SCAN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from the state register.
    always_comb begin
        go        = (state_q == S_GO_HI);
        busy      = (state_q != S_IDLE);
        hit_ready = (state_q == S_IDLE) && !start;
    end

    // Counts the two cycles go stays high.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            go_cnt_q <= 1'b0;
        end else if (state_q == S_GO_HI) begin
            go_cnt_q <= ~go_cnt_q;
        end else begin
            go_cnt_q <= 1'b0;
        end
    end

    // Bitmap, cursor and job latches; x/y/colour only change when a job is launched.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            alive_q   <= '1;
            left_q    <= 8'(NB);
            row_q     <= 3'd0;
            col_q     <= 4'd0;
            job_hit_q <= 1'b0;
            x_q       <= 10'd0;
            y_q       <= 10'd0;
            colour_q  <= 3'b000;
`ifdef BRICK_TOUGH_EN
            cracked_q <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        row_q     <= 3'd0;
                        col_q     <= 4'd0;
                        job_hit_q <= 1'b0;
                    end else if (hit_valid) begin
                        row_q     <= hit_row;
                        col_q     <= hit_col;
                        job_hit_q <= 1'b1;
                    end
                end
                S_SCAN: begin
                    if (alive_s) begin
                        x_q      <= x_s;
                        y_q      <= y_s;
                        colour_q <= scan_colour_s;
                    end else if (!last_s) begin
                        row_q <= nxt_row_s;
                        col_q <= nxt_col_s;
                    end
                end
                S_HIT: begin
                    if (alive_s) begin
                        x_q <= x_s;
                        y_q <= y_s;
`ifdef BRICK_TOUGH_EN
                        if ((row_q == 3'd0) && !cracked_s) begin
                            cracked_q <= cracked_q | col_sel_s;
                            colour_q  <= 3'b100;
                        end else begin
                            alive_q  <= alive_q & ~sel_s;
                            left_q   <= left_q - 8'd1;
                            colour_q <= 3'b000;
                        end
`else
                        alive_q  <= alive_q & ~sel_s;
                        left_q   <= left_q - 8'd1;
                        colour_q <= 3'b000;
`endif
                    end
                end
                S_WAIT: begin
                    if (draw_done && !job_hit_q && !last_s) begin
                        row_q <= nxt_row_s;
                        col_q <= nxt_col_s;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign x_out       = x_q;
    assign y_out       = y_q;
    assign colour      = colour_q;
    assign width       = 10'(BRICK_W);
    assign height      = 10'(BRICK_H);
    assign bricks_left = left_q;
    assign field_clear = (left_q == 8'd0);

endmodule

// File: tb/tb_brick_field_sequencer.sv
// Scoreboard bench for brick_field_sequencer: stimulus pushes expected draw
// jobs into a queue, a monitor pops and compares on each rising go, and a
// drawer model answers with draw_done five cycles after go falls.
module tb_brick_field_sequencer;
    localparam int ROWS = 4;
    localparam int COLS = 8;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [2:0] c;
    } job_t;

    logic       clk = 1'b0;
    logic       resetn, start, hit_valid, draw_done;
    logic [2:0] hit_row;
    logic [3:0] hit_col;
    logic       hit_ready, go, busy, field_clear;
    logic [9:0] x_out, y_out, width, height;
    logic [2:0] colour;
    logic [7:0] bricks_left;

    int   checks = 0;
    int   errors = 0;
    job_t exp_q[$];
    job_t obs_q[$];
    bit   m_alive[ROWS][COLS];
    bit   m_cracked[COLS];
    int   m_left;

    always #5 clk = ~clk;

    brick_field_sequencer dut (
        .clk(clk), .resetn(resetn), .start(start), .hit_valid(hit_valid),
        .hit_row(hit_row), .hit_col(hit_col), .hit_ready(hit_ready),
        .draw_done(draw_done), .go(go), .x_out(x_out), .y_out(y_out),
        .width(width), .height(height), .colour(colour), .busy(busy),
        .bricks_left(bricks_left), .field_clear(field_clear)
    );

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic logic [2:0] scan_colour(input int r, input int c);
`ifdef BRICK_TOUGH_EN
        if (r == 0) return m_cracked[c] ? 3'b100 : 3'b101;
`endif
        case (r % 4)
            0: return 3'b100;
            1: return 3'b110;
            2: return 3'b010;
            default: return 3'b011;
        endcase
    endfunction

    function automatic job_t mk_job(input int r, input int c, input logic [2:0] col);
        job_t j;
        j.x = 10'(c * 42);
        j.y = 10'(32 + r * 18);
        j.c = col;
        return j;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) m_alive[r][c] = 1'b1;
        for (int c = 0; c < COLS; c++) m_cracked[c] = 1'b0;
        m_left = ROWS * COLS;
    endtask

    task automatic push_scan();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (m_alive[r][c]) exp_q.push_back(mk_job(r, c, scan_colour(r, c)));
    endtask

    // Applies a hit to the model; returns whether a draw job results.
    task automatic model_hit(input int r, input int c, output bit ok);
        ok = 1'b0;
        if (r < ROWS && c < COLS) begin
            if (m_alive[r][c]) begin
                ok = 1'b1;
`ifdef BRICK_TOUGH_EN
                if (r == 0 && !m_cracked[c]) begin
                    m_cracked[c] = 1'b1;
                    exp_q.push_back(mk_job(r, c, 3'b100));
                    return;
                end
`endif
                m_alive[r][c] = 1'b0;
                m_left--;
                exp_q.push_back(mk_job(r, c, 3'b000));
            end
        end
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout busy=1 required=0", nm);
        end
    endtask

    task automatic do_start();
        push_scan();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle("scan");
        chk("scan_queue_drained", exp_q.size(), 0);
    endtask

    task automatic do_hit(input int r, input int c);
        bit ok;
        @(negedge clk);
        hit_row   = 3'(r);
        hit_col   = 4'(c);
        hit_valid = 1'b1;
        #1;
        chk("hit_ready", hit_ready, 1);
        model_hit(r, c, ok);
        @(negedge clk);
        hit_valid = 1'b0;
        @(negedge clk);
        chk("hit_go_latency", go, ok);
        if (!ok) chk("hit_ignored_idle", busy, 0);
        wait_idle("hit");
        chk("bricks_left", bricks_left, m_left);
    endtask

    // Monitor: scoreboard compare on every rising go, and go pulse width.
    initial begin
        logic go_p;
        int   hi_len;
        job_t a, e;
        go_p   = 1'b0;
        hi_len = 0;
        forever begin
            @(negedge clk);
            if (go && !go_p) begin
                a.x = x_out;
                a.y = y_out;
                a.c = colour;
                obs_q.push_back(a);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_job x=%0d y=%0d colour=%0d required=none", a.x, a.y, a.c);
                end else begin
                    e = exp_q.pop_front();
                    checks++;
                    if (a != e) begin
                        errors++;
                        $display("FAIL job actual=(%0d,%0d,%0d) required=(%0d,%0d,%0d)",
                                 a.x, a.y, a.c, e.x, e.y, e.c);
                    end
                end
            end
            if (go) begin
                hi_len++;
            end else begin
                if (go_p) chk("go_width", hi_len, 2);
                hi_len = 0;
            end
            go_p = go;
        end
    end

    // Drawer model: one-cycle draw_done five cycles after go falls.
    initial begin
        int   cnt;
        logic gp;
        cnt       = 0;
        gp        = 1'b0;
        draw_done = 1'b0;
        forever begin
            @(negedge clk);
            draw_done = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) draw_done = 1'b1;
            end
            if (gp && !go) cnt = 5;
            gp = go;
        end
    end

    initial begin
        int n;
        bit ok;
        job_t j;
        resetn = 1'b0; start = 1'b0; hit_valid = 1'b0; hit_row = 3'd0; hit_col = 4'd0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_go", go, 0);
        chk("rst_left", bricks_left, 32);
        chk("rst_clear", field_clear, 0);
        chk("rst_width", width, 40);
        chk("rst_height", height, 16);
        chk("rst_xyc", {x_out, y_out, colour}, 0);
        resetn = 1'b1;

        // Full redraw: 32 jobs in row-major order.
        do_start();
        chk("scan_jobs", obs_q.size(), 32);
        j = obs_q[9];
        chk("job9_x", j.x, 42);
        chk("job9_y", j.y, 50);
        chk("job9_colour", j.c, 3'b110);
        chk("scan_left", bricks_left, 32);

        // Hit (2,3), then same brick again, then out-of-range cells.
        do_hit(2, 3);
        j = obs_q[obs_q.size() - 1];
        chk("hit_x", j.x, 126);
        chk("hit_y", j.y, 68);
        chk("hit_colour", j.c, 0);
        chk("hit_left", bricks_left, 31);
        do_hit(2, 3);
        do_hit(5, 0);
        do_hit(0, 9);
        chk("ignored_left", bricks_left, 31);

        // start and hit together: scan first, hit after; mid-scan start ignored.
        push_scan();
        @(negedge clk);
        start = 1'b1; hit_valid = 1'b1; hit_row = 3'd1; hit_col = 4'd2;
        #1;
        chk("hit_ready_vs_start", hit_ready, 0);
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);
        chk("busy_mid_scan", busy, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!hit_ready && n < 3000);
        chk("hit_after_scan", hit_ready, 1);
        model_hit(1, 2, ok);
        @(negedge clk);
        hit_valid = 1'b0;
        wait_idle("deferred_hit");
        chk("deferred_left", bricks_left, 30);
        chk("deferred_drained", exp_q.size(), 0);

        // Clear the whole field, then an empty scan.
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) do_hit(r, c);
`ifdef BRICK_TOUGH_EN
        for (int c = 0; c < COLS; c++) do_hit(0, c);
`endif
        chk("clear_flag", field_clear, 1);
        chk("clear_left", bricks_left, 0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("empty_scan_cycles", n, 32);

        // Reset mid-job restores the field and drops go.
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        model_reset();
        chk("rerst_left", bricks_left, 32);
        do_hit(3, 0);
        chk("pre_wait_left", bricks_left, 31);
        @(negedge clk);
        hit_row = 3'd3; hit_col = 4'd1; hit_valid = 1'b1;
        model_hit(3, 1, ok);
        @(negedge clk);
        hit_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("in_wait_busy", busy, 1);
        chk("in_wait_go", go, 0);
        resetn = 1'b0;
        @(negedge clk);
        chk("reset_wait_go", go, 0);
        chk("reset_wait_left", bricks_left, 32);
        chk("reset_wait_busy", busy, 0);
        resetn = 1'b1;
        model_reset();
        repeat (10) @(negedge clk);

`ifdef BRICK_TOUGH_EN
        do_hit(0, 0);
        j = obs_q[obs_q.size() - 1];
        chk("tough_first_colour", j.c, 3'b100);
        chk("tough_first_left", bricks_left, 32);
        do_hit(0, 0);
        j = obs_q[obs_q.size() - 1];
        chk("tough_second_colour", j.c, 0);
        chk("tough_second_left", bricks_left, 31);
`endif

        chk("final_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
